// File: rtl/wait_cond_seq.sv
// Sequenced wait-for-condition engine: walks a small table of signed compare
// conditions against a watched value, with an optional per-step timeout.
module wait_cond_seq #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TMO_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
    input  logic [2:0]                 cfg_op,
    input  logic signed [WIDTH-1:0]    cfg_lo,
    input  logic signed [WIDTH-1:0]    cfg_hi,
    input  logic [$clog2(DEPTH):0]     cfg_len,
    input  logic [TMO_W-1:0]           timeout,
    input  logic                       start,
    input  logic                       abort,
    input  logic signed [WIDTH-1:0]    value,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       step_hit,
    output logic                       done,
    output logic                       timed_out
);

    localparam int IW = $clog2(DEPTH);
    localparam int LW = IW + 1;

    typedef enum logic [0:0] {StIdle, StWait} state_t;

    state_t                  state_q;
    logic [2:0]              op_q [DEPTH];
    logic signed [WIDTH-1:0] lo_q [DEPTH];
    logic signed [WIDTH-1:0] hi_q [DEPTH];
    logic [LW-1:0]           len_q;
    logic [TMO_W-1:0]        tmo_q;
    logic [TMO_W-1:0]        timer_q;

    logic [LW-1:0]           len_eff;
    logic                    cond;
    logic                    last;
    logic                    expire;

    function automatic logic eval_cond(input logic [2:0] op,
                                       input logic signed [WIDTH-1:0] v,
                                       input logic signed [WIDTH-1:0] lo,
                                       input logic signed [WIDTH-1:0] hi);
        logic r;
        case (op)
            3'd0:    r = (v == lo);
            3'd1:    r = (v != lo);
            3'd2:    r = (v < lo);
            3'd3:    r = (v > lo);
            3'd4:    r = (v > lo) && (v < hi);
            3'd5:    r = (v <= lo);
            3'd6:    r = (v >= lo);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        len_eff = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
        cond    = eval_cond(op_q[step_idx], value, lo_q[step_idx], hi_q[step_idx]);
        last    = (LW'(step_idx) == len_q - LW'(1));
        // Expiry fires on the T-th consecutive unsatisfied cycle of a step.
        expire  = (tmo_q != '0) && (timer_q >= tmo_q - TMO_W'(1));
    end

    // Table has no reset; it is only writable while idle.
    always_ff @(posedge clk) begin
        if (!rst && cfg_we && state_q == StIdle) begin
            op_q[cfg_idx] <= cfg_op;
            lo_q[cfg_idx] <= cfg_lo;
            hi_q[cfg_idx] <= cfg_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            step_idx  <= '0;
            step_hit  <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            timer_q   <= '0;
            len_q     <= '0;
            tmo_q     <= '0;
        end else begin
            step_hit  <= 1'b0;
            done      <= 1'b0;
            timed_out <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len_eff == '0) begin
                            done <= 1'b1;
                        end else begin
                            state_q  <= StWait;
                            busy     <= 1'b1;
                            step_idx <= '0;
                            timer_q  <= '0;
                            len_q    <= len_eff;
                            tmo_q    <= timeout;
                        end
                    end
                end
                StWait: begin
                    if (abort) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end else if (cond) begin
                        step_hit <= 1'b1;
                        timer_q  <= '0;
                        if (last) begin
                            done    <= 1'b1;
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end else begin
                            step_idx <= step_idx + IW'(1);
                        end
                    end else if (expire) begin
                        timed_out <= 1'b1;
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wait_cond_seq.sv
// Self-checking bench for wait_cond_seq: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural model.
module tb_wait_cond_seq;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TMO_W = 16;
    localparam int IW    = $clog2(DEPTH);
    localparam int LW    = IW + 1;
    localparam int VW    = IW + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, cfg_we, start, abort;
    logic [IW-1:0]           cfg_idx;
    logic [2:0]              cfg_op;
    logic signed [WIDTH-1:0] cfg_lo, cfg_hi, value;
    logic [LW-1:0]           cfg_len;
    logic [TMO_W-1:0]        timeout;
    logic                    busy, step_hit, done, timed_out;
    logic [IW-1:0]           step_idx;

    wait_cond_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_op(cfg_op),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_len(cfg_len), .timeout(timeout),
        .start(start), .abort(abort), .value(value), .busy(busy), .step_idx(step_idx),
        .step_hit(step_hit), .done(done), .timed_out(timed_out)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the table plus "which step, how long unsatisfied".
    logic [2:0]              m_op [DEPTH];
    logic signed [WIDTH-1:0] m_lo [DEPTH];
    logic signed [WIDTH-1:0] m_hi [DEPTH];
    bit m_busy = 0, m_hit = 0, m_done = 0, m_to = 0;
    int m_idx = 0, m_len = 0, m_tmo = 0, m_miss = 0;

    function automatic bit sat(input logic [2:0] op, input logic signed [WIDTH-1:0] v,
                               input logic signed [WIDTH-1:0] lo,
                               input logic signed [WIDTH-1:0] hi);
        case (op)
            3'd0:    return v == lo;
            3'd1:    return v != lo;
            3'd2:    return v < lo;
            3'd3:    return v > lo;
            3'd4:    return (lo < v) && (v < hi);
            3'd5:    return v <= lo;
            3'd6:    return v >= lo;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_step();
        m_hit = 0; m_done = 0; m_to = 0;
        if (rst) begin
            m_busy = 0; m_idx = 0; m_miss = 0;
        end else if (!m_busy) begin
            if (cfg_we) begin
                m_op[cfg_idx] = cfg_op; m_lo[cfg_idx] = cfg_lo; m_hi[cfg_idx] = cfg_hi;
            end
            if (start) begin
                m_len = (int'(cfg_len) > DEPTH) ? DEPTH : int'(cfg_len);
                if (m_len == 0) m_done = 1;
                else begin
                    m_busy = 1; m_idx = 0; m_miss = 0; m_tmo = int'(timeout);
                end
            end
        end else if (abort) begin
            m_busy = 0;
        end else if (sat(m_op[m_idx], value, m_lo[m_idx], m_hi[m_idx])) begin
            m_hit = 1;
            if (m_idx == m_len - 1) begin
                m_done = 1; m_busy = 0;
            end else begin
                m_idx++; m_miss = 0;
            end
        end else begin
            m_miss++;
            if (m_tmo != 0 && m_miss >= m_tmo) begin
                m_to = 1; m_busy = 0;
            end
        end
    endtask

    function automatic logic [VW-1:0] obs();
        return {busy, step_idx, step_hit, done, timed_out};
    endfunction

    function automatic logic [VW-1:0] expv();
        return {m_busy, IW'(m_idx), m_hit, m_done, m_to};
    endfunction

    function automatic logic signed [WIDTH-1:0] rv();
        int r = int'($urandom_range(0, 6));
        return WIDTH'(r - 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; cfg_we = 0; cfg_idx = '0; cfg_op = '0; cfg_lo = '0; cfg_hi = '0;
        cfg_len = '0; timeout = '0; start = 0; abort = 0; value = '0;
    endtask

    task automatic write_entry(input int idx, input int op, input int lo, input int hi);
        cfg_we = 1; cfg_idx = IW'(idx); cfg_op = 3'(op); cfg_lo = WIDTH'(lo); cfg_hi = WIDTH'(hi);
        tick();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; start = 1; abort = 1; cfg_we = 1; cfg_len = LW'(2);
        repeat (2) begin
            tick();
            checks++;
            if (obs() !== VW'(0)) begin
                failures++;
                $display("FAIL reset got=%b exp=%b", obs(), VW'(0));
            end
        end
        idle_inputs();
    endtask

    task automatic test_seq_basic();
        int hits[$];
        int exp_h [4] = '{201, 301, 302, 401};
        int done_at = -1;
        bit ok;
        write_entry(0, 0, 2, 0);
        write_entry(1, 2, 2, 0);
        write_entry(2, 0, 0, 0);
        write_entry(3, 4, 1, 3);
        cfg_len = LW'(4); timeout = '0;
        for (int c = 0; c <= 420; c++) begin
            start = (c == 0);
            value = (c < 100) ? 0 : (c < 200) ? 1 : (c < 300) ? 2 : (c < 400) ? 0 : 2;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL seq_basic c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (step_hit === 1'b1) hits.push_back(c + 1);
            if (done === 1'b1) done_at = c + 1;
        end
        start = 0;
        ok = (hits.size() == 4);
        for (int i = 0; i < 4; i++) if (ok && hits[i] != exp_h[i]) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL seq_hits got_count=%0d first=%0d exp=201,301,302,401",
                     hits.size(), (hits.size() > 0) ? hits[0] : -1);
        end
        checks++;
        if (done_at != 401) begin
            failures++;
            $display("FAIL seq_done got=%0d exp=401", done_at);
        end
    endtask

    task automatic test_timeout();
        int to_at, hit_at, done_cnt, to_cnt;
        write_entry(0, 0, 5, 0);
        cfg_len = LW'(1); timeout = TMO_W'(10);
        // Held unsatisfied: expires on the 10th WAIT cycle.
        to_at = -1; done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0); value = 0;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL timeout c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (timed_out === 1'b1) to_at = c;
            if (done === 1'b1) done_cnt++;
        end
        checks++;
        if (to_at != 10 || done_cnt != 0) begin
            failures++;
            $display("FAIL timeout_pulse got=%0d/%0d exp=10/0", to_at, done_cnt);
        end
        // Satisfied exactly on the expiry cycle: the hit wins.
        hit_at = -1; to_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0); value = (c == 10) ? 5 : 0;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL hit_vs_tmo c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (step_hit === 1'b1 && done === 1'b1) hit_at = c;
            if (timed_out === 1'b1) to_cnt++;
        end
        start = 0;
        checks++;
        if (hit_at != 10 || to_cnt != 0) begin
            failures++;
            $display("FAIL hit_vs_tmo_pulse got=%0d/%0d exp=10/0", hit_at, to_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] hit_mask = '0;
        logic [7:0] done_mask = '0;
        for (int i = 0; i < 3; i++) write_entry(i, 7, 0, 0);
        cfg_len = LW'(3); timeout = '0;
        for (int c = 0; c < 8; c++) begin
            start = (c <= 3);
            value = rv();
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (step_hit === 1'b1) hit_mask[c] = 1'b1;
            if (done === 1'b1) done_mask[c] = 1'b1;
        end
        start = 0;
        checks++;
        if (hit_mask !== 8'b0000_1110 || done_mask !== 8'b0000_1000) begin
            failures++;
            $display("FAIL b2b_pulses got=%b/%b exp=00001110/00001000", hit_mask, done_mask);
        end
    endtask

    task automatic test_abort_reset();
        int done_cnt;
        bit fired;
        bit seen_done;
        for (int i = 0; i < 4; i++) write_entry(i, 0, i + 1, 0);
        cfg_len = LW'(4); timeout = '0;
        done_cnt = 0; fired = 0;
        for (int c = 0; c < 10; c++) begin
            start = (c == 0);
            value = WIDTH'(m_idx + 1);
            abort = m_busy && m_idx == 2 && !fired;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL abort c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (abort && (busy !== 1'b0 || step_hit !== 1'b0 || done !== 1'b0)) begin
                failures++;
                $display("FAIL abort_idle got=%b exp=busy,hit,done low", obs());
            end
            if (abort) begin
                checks++;
                fired = 1;
            end
            if (done === 1'b1) done_cnt++;
            abort = 0;
        end
        checks++;
        if (!fired || done_cnt != 0) begin
            failures++;
            $display("FAIL abort_done got=%0d exp=0 (abort_seen=%0d)", done_cnt, fired);
        end
        // Rerun, reset at step 1, then a full rerun on the surviving table.
        fired = 0;
        for (int c = 0; c < 6 && !fired; c++) begin
            start = (c == 0);
            value = WIDTH'(m_idx + 1);
            rst = m_busy && m_idx == 1;
            tick();
            if (rst) begin
                fired = 1;
                checks++;
                if (obs() !== VW'(0)) begin
                    failures++;
                    $display("FAIL mid_reset got=%b exp=%b", obs(), VW'(0));
                end
            end
            rst = 0;
        end
        seen_done = 0;
        for (int c = 0; c < 8; c++) begin
            start = (c == 0);
            value = WIDTH'(m_idx + 1);
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rerun c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (done === 1'b1) seen_done = 1;
        end
        start = 0;
        checks++;
        if (!fired || !seen_done) begin
            failures++;
            $display("FAIL rerun_done got=%0d exp=1 (reset_seen=%0d)", seen_done, fired);
        end
    endtask

    task automatic test_signed();
        logic [3:0] hit_mask = '0;
        write_entry(0, 2, 0, 0);
        write_entry(1, 4, -3, 0);
        cfg_len = LW'(2); timeout = TMO_W'(5);
        for (int c = 0; c < 4; c++) begin
            start = (c == 0); value = -1;
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL signed c=%0d got=%b exp=%b", c, obs(), expv());
            end
            if (step_hit === 1'b1) hit_mask[c] = 1'b1;
        end
        checks++;
        if (hit_mask !== 4'b0110) begin
            failures++;
            $display("FAIL signed_hits got=%b exp=0110", hit_mask);
        end
        cfg_len = '0; start = 1;
        tick();
        start = 0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || step_hit !== 1'b0) begin
            failures++;
            $display("FAIL len0 got=%b exp=done only", obs());
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL len0_after got=%b exp=idle", obs());
        end
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) write_entry(i, int'($urandom_range(0, 7)), int'(rv()), int'(rv()));
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            cfg_we  = ($urandom_range(0, 3) == 0);
            cfg_idx = IW'($urandom_range(0, DEPTH - 1));
            cfg_op  = 3'($urandom_range(0, 7));
            cfg_lo  = rv();
            cfg_hi  = rv();
            cfg_len = LW'($urandom_range(0, 2 * DEPTH - 1));
            timeout = ($urandom_range(0, 3) == 0) ? '0 : TMO_W'($urandom_range(1, 6));
            start   = ($urandom_range(0, 4) == 0);
            abort   = ($urandom_range(0, 24) == 0);
            value   = rv();
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random c=%0d got=%b exp=%b", c, obs(), expv());
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_seq_basic();
        test_timeout();
        test_back_to_back();
        test_abort_reset();
        test_signed();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
